// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-128 sequencing controller.
// The optional abort input is enabled by defining ASCON_FSM_ABORT_EN.
package ascon_pack;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        WAIT_AD = 3'd2,
        RUN_AD  = 3'd3,
        WAIT_PT = 3'd4,
        RUN_PT  = 3'd5,
        RUN_FIN = 3'd6,
        DONE    = 3'd7
    } type_fsm_state;

    localparam logic [3:0] ROUND_FIRST_PA = 4'd0;
    localparam logic [3:0] ROUND_FIRST_PB = 4'd6;
    localparam logic [3:0] ROUND_LAST     = 4'd11;

    function automatic logic is_last_round(input logic [3:0] round);
        return (round == ROUND_LAST);
    endfunction

endpackage

// File: rtl/ascon_fsm_round_counter.sv
// Round index counter for the ASCON permutation: loads the first round of
// the a- or b-permutation and saturates at the last round.
import ascon_pack::*;

module round_counter (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       init_a_i,
    input  logic       init_b_i,
    input  logic       en_i,
    output logic [3:0] counter_o
);

    logic [3:0] r_counter;

    // Round index register; a load of 0 has priority over a load of 6.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_counter <= 4'd0;
        end else if (init_a_i) begin
            r_counter <= ROUND_FIRST_PA;
        end else if (init_b_i) begin
            r_counter <= ROUND_FIRST_PB;
        end else if (en_i && !is_last_round(r_counter)) begin
            r_counter <= r_counter + 4'd1;
        end else begin
            r_counter <= r_counter;
        end
    end

    assign counter_o = r_counter;

endmodule

// File: rtl/ascon_fsm.sv
// ASCON-128 encryption sequencer driving a one-round-per-clock permutation.
// Define ASCON_FSM_ABORT_EN to add the abort_i input.
import ascon_pack::*;

module ascon_fsm #(
    parameter int NB_AD_BLOCKS = 1,
    parameter int NB_PT_BLOCKS = 3
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic       data_sel_o,
    output logic       en_reg_state_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_lsb_o,
    output logic [3:0] counter_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       cipher_valid_o,
    output logic       busy_o,
    output logic       done_o
`ifdef ASCON_FSM_ABORT_EN
    ,
    input  logic       abort_i
`endif
);

    localparam int AD_W = $clog2(NB_AD_BLOCKS + 1);
    localparam int PT_W = $clog2(NB_PT_BLOCKS + 1);
    localparam logic [AD_W-1:0] AD_LAST_CNT  = AD_W'(NB_AD_BLOCKS);
    localparam logic [PT_W-1:0] PT_FINAL_IDX = PT_W'(NB_PT_BLOCKS - 1);

    type_fsm_state   r_state;
    logic [AD_W-1:0] r_ad_cnt;
    logic [PT_W-1:0] r_pt_cnt;
    logic            r_cipher_valid;

    logic            w_cnt_init_a;
    logic            w_cnt_init_b;
    logic            w_cnt_en;
    logic            w_last_round;
    logic            w_ad_last;
    logic            w_pt_final;
    logic            w_abort;

`ifdef ASCON_FSM_ABORT_EN
    assign w_abort = abort_i && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_last_round = is_last_round(counter_o);
    // r_ad_cnt already includes the block currently in its rounds.
    assign w_ad_last    = (r_ad_cnt == AD_LAST_CNT);
    // r_pt_cnt counts accepted blocks, so this flags the next block to accept.
    assign w_pt_final   = (r_pt_cnt == PT_FINAL_IDX);

    round_counter u_round_counter (
        .clock_i   (clock_i),
        .resetb_i  (resetb_i),
        .init_a_i  (w_cnt_init_a),
        .init_b_i  (w_cnt_init_b),
        .en_i      (w_cnt_en),
        .counter_o (counter_o)
    );

    // Datapath enables and round-counter control decoded from the state.
    always_comb begin
        data_ready_o     = 1'b0;
        data_sel_o       = 1'b0;
        en_reg_state_o   = 1'b0;
        en_xor_data_o    = 1'b0;
        en_xor_key_o     = 1'b0;
        en_xor_key_end_o = 1'b0;
        en_xor_lsb_o     = 1'b0;
        en_cipher_o      = 1'b0;
        en_tag_o         = 1'b0;
        done_o           = 1'b0;
        w_cnt_init_a     = 1'b0;
        w_cnt_init_b     = 1'b0;
        w_cnt_en         = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_init_a = 1'b1;
            end
            INIT: begin
                en_reg_state_o   = 1'b1;
                data_sel_o       = (counter_o != ROUND_FIRST_PA);
                en_xor_key_end_o = w_last_round;
                w_cnt_init_b     = w_last_round;
                w_cnt_en         = !w_last_round;
            end
            WAIT_AD: begin
                data_ready_o = 1'b1;
                data_sel_o   = 1'b1;
                if (data_valid_i) begin
                    en_xor_data_o  = 1'b1;
                    en_reg_state_o = 1'b1;
                    w_cnt_en       = 1'b1;
                end else begin
                    w_cnt_en = 1'b0;
                end
            end
            RUN_AD: begin
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                if (w_last_round) begin
                    en_xor_lsb_o = w_ad_last;
                    // A single-block plaintext starts straight at the a-permutation.
                    w_cnt_init_a = w_ad_last && w_pt_final;
                    w_cnt_init_b = !(w_ad_last && w_pt_final);
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            WAIT_PT: begin
                data_ready_o = 1'b1;
                data_sel_o   = 1'b1;
                if (data_valid_i) begin
                    en_xor_data_o  = 1'b1;
                    en_cipher_o    = 1'b1;
                    en_reg_state_o = 1'b1;
                    en_xor_key_o   = w_pt_final;
                    w_cnt_en       = 1'b1;
                end else begin
                    w_cnt_en = 1'b0;
                end
            end
            RUN_PT: begin
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                if (w_last_round) begin
                    w_cnt_init_a = w_pt_final;
                    w_cnt_init_b = !w_pt_final;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            RUN_FIN: begin
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                if (w_last_round) begin
                    en_xor_key_end_o = 1'b1;
                    en_tag_o         = 1'b1;
                    w_cnt_init_a     = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            DONE: begin
                done_o       = 1'b1;
                w_cnt_init_a = 1'b1;
            end
            default: begin
                w_cnt_init_a = 1'b1;
            end
        endcase
        if (w_abort) begin
            w_cnt_init_a = 1'b1;
        end else begin
            w_cnt_init_a = w_cnt_init_a;
        end
    end

    assign busy_o         = (r_state != IDLE);
    assign cipher_valid_o = r_cipher_valid;

    // Main sequencing FSM with block counters and the cipher-valid flag.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state        <= IDLE;
            r_ad_cnt       <= {AD_W{1'b0}};
            r_pt_cnt       <= {PT_W{1'b0}};
            r_cipher_valid <= 1'b0;
        end else if (w_abort) begin
            r_state        <= IDLE;
            r_ad_cnt       <= {AD_W{1'b0}};
            r_pt_cnt       <= {PT_W{1'b0}};
            r_cipher_valid <= 1'b0;
        end else begin
            r_cipher_valid <= en_cipher_o;
            case (r_state)
                IDLE: begin
                    r_ad_cnt <= {AD_W{1'b0}};
                    r_pt_cnt <= {PT_W{1'b0}};
                    if (start_i) begin
                        r_state <= INIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                INIT: begin
                    if (w_last_round) begin
                        r_state <= WAIT_AD;
                    end else begin
                        r_state <= INIT;
                    end
                end
                WAIT_AD: begin
                    if (data_valid_i) begin
                        r_ad_cnt <= r_ad_cnt + AD_W'(1);
                        r_state  <= RUN_AD;
                    end else begin
                        r_state <= WAIT_AD;
                    end
                end
                RUN_AD: begin
                    if (w_last_round) begin
                        r_state <= w_ad_last ? WAIT_PT : WAIT_AD;
                    end else begin
                        r_state <= RUN_AD;
                    end
                end
                WAIT_PT: begin
                    if (data_valid_i) begin
                        r_pt_cnt <= r_pt_cnt + PT_W'(1);
                        r_state  <= w_pt_final ? RUN_FIN : RUN_PT;
                    end else begin
                        r_state <= WAIT_PT;
                    end
                end
                RUN_PT: begin
                    if (w_last_round) begin
                        r_state <= WAIT_PT;
                    end else begin
                        r_state <= RUN_PT;
                    end
                end
                RUN_FIN: begin
                    if (w_last_round) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= RUN_FIN;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
